mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data-access port. Sits between the CPU core (IF and MEM stages) and the unified memory. Serialises one outstanding transaction at a time with a fixed data-first priority and an anti-starvation streak limit for fetch. Per-port completion pulses double as the core's stall release.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width.
- `MAX_D_STREAK`, default 4: maximum number of consecutive data grants allowed while a fetch is waiting.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_req` input 1: fetch request level; held until `i_done`.
- `i_addr` input ADDR_W: fetch address.
- `i_flush` input 1: cancels the pending or in-flight fetch (branch redirect).
- `i_done` output 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` output DATA_W: fetched instruction.
- `d_req` input 1: data request level; held until `d_done`.
- `d_we` input 1: 1 means write, 0 means read.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: store data.
- `d_done` output 1: one-cycle pulse; `d_rdata` is valid for reads.
- `d_rdata` output DATA_W: load data.
- `mem_req_valid` output 1: request to memory.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_we` output 1: write enable.
- `mem_addr` output ADDR_W: address to memory.
- `mem_wdata` output DATA_W: write data to memory.
- `mem_resp_valid` input 1: response pulse; issued for both reads and writes.
- `mem_rdata` input DATA_W: read data from memory.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If either request is live, latch the grant owner and the `we`/`addr`/`wdata` fields, then go to ISSUE.
  - A fetch request is live only when `i_req` is high and `i_flush` is low.
- ISSUE:
  - `mem_req_valid` is high and the latched fields are driven.
  - Fields are held stable until `mem_req_ready` is sampled high; the FSM then goes to WAIT.
- WAIT:
  - On `mem_resp_valid`, register `mem_rdata` into the owner's rdata output, pulse the owner's done for the next cycle, and go to IDLE.
- Priority:
  - Data wins over fetch by default.
  - Fetch wins if both requests are live and the streak counter equals MAX_D_STREAK.
- Streak counter:
  - Increments on a data grant while `i_req` is high, saturating at MAX_D_STREAK.
  - Clears on any fetch grant, and in any cycle where `i_req` is low.
- Flush:
  - `i_flush` in IDLE suppresses the fetch grant that cycle.
  - `i_flush` while a fetch owns ISSUE or WAIT sets a drop flag. The transaction still completes on the memory side (no abort), `i_done` is not pulsed, and `i_rdata` is unchanged.
  - `i_flush` has no effect on data transactions.
- `mem_resp_valid` in IDLE or ISSUE is ignored.
- `i_rdata`/`d_rdata` hold their last value until overwritten.

## Timing
- Reset values: state IDLE; streak 0; drop flag 0. Every output (`i_done`, `d_done`, `i_rdata`, `d_rdata`, `mem_req_valid`, `mem_we`, `mem_addr`, `mem_wdata`) is 0.
- Reset asserted mid-transaction abandons it, with no done pulse. The memory shares the same reset.
- Request path: request live in cycle 0 while IDLE → `mem_req_valid` high in cycle 1.
- Accept: `mem_req_ready` sampled high in cycle k → `mem_req_valid` low in k+1.
- Response: `mem_resp_valid` is never earlier than the cycle after acceptance. `mem_resp_valid` in cycle r → done high in r+1 only, with rdata valid in r+1.
- Minimum request-to-done: 3 cycles. The FSM is IDLE in r+1, so the next grant has `mem_req_valid` in r+2.
- A requester must deassert its req, or present a new request, in the cycle after done. A req still high in the done cycle is treated as a new request.
- A flush in the same cycle as `mem_resp_valid` for an owned fetch → drop; no `i_done`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - the owner encoding (OWN_I, OWN_D);
  - default width constants.
- Sub-module `arb_priority_select`: combinational grant decision from `i_live`, `d_req`, and the streak-at-limit flag.
- Remaining FSM, latches and counter are in the top module.

## Test plan
- Fetch only: `i_req`=1, `i_addr`=0x40, memory ready immediately, response 1 cycle after accept with 0x00500093 → `i_done` 3 cycles after request, `i_rdata`=0x00500093.
- Both request in the same IDLE cycle (`d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF) → data granted first with `mem_we`=1. Fetch is issued in the cycle after `d_done`.
- `d_req` held high continuously with `i_req` high, MAX_D_STREAK=4 → grant order D,D,D,D,I,D…; the streak clears after the fetch grant.
- Memory holds `mem_req_ready` low for 5 cycles → `mem_req_valid`, `mem_addr`, `mem_wdata` stable throughout; WAIT entered only after acceptance.
- Fetch in WAIT, `i_flush` pulsed 1 cycle before response → no `i_done`, `i_rdata` unchanged. A following `d_req` is granted normally.
- Reset deasserted-low (asserted) during WAIT → all outputs 0 immediately. After release with no requests pending, `mem_req_valid` stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned AddrWDefault      = 32;
  localparam int unsigned DataWDefault      = 32;
  localparam int unsigned MaxDStreakDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_priority_select.sv
// Grant decision: data wins unless a live fetch has waited out the data streak limit.
module arb_priority_select
  import mem_arb_pkg::*;
(
  input  logic   i_fetch_live,
  input  logic   i_data_req,
  input  logic   i_at_limit,
  output logic   o_grant,
  output owner_e o_owner
);

  always_comb begin
    o_grant = i_fetch_live | i_data_req;
    o_owner = OwnD;
    if (i_fetch_live && (!i_data_req || i_at_limit)) begin
      o_owner = OwnI;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port,
// one outstanding transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDefault,
  parameter int unsigned DATA_W       = DataWDefault,
  parameter int unsigned MAX_D_STREAK = MaxDStreakDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  owner_e              r_owner;
  owner_e              w_grant_owner;
  logic                r_drop;
  logic [StreakW-1:0]  r_streak;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_i_done;
  logic                r_d_done;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic w_i_live;
  logic w_at_limit;
  logic w_grant;
  logic w_grant_fire;
  logic w_resp;
  logic w_fetch_owned;
  logic w_i_deliver;
  logic w_d_deliver;

  assign w_i_live      = i_req & ~i_flush;
  assign w_at_limit    = (r_streak == StreakW'(MAX_D_STREAK));
  assign w_grant_fire  = (r_state == StIdle) & w_grant;
  assign w_resp        = (r_state == StWait) & mem_resp_valid;
  assign w_fetch_owned = (r_state != StIdle) & (r_owner == OwnI);
  // A flush coinciding with the response still drops the fetch.
  assign w_i_deliver   = w_resp & (r_owner == OwnI) & ~(r_drop | i_flush);
  assign w_d_deliver   = w_resp & (r_owner == OwnD);

  arb_priority_select u_prio (
    .i_fetch_live (w_i_live),
    .i_data_req   (d_req),
    .i_at_limit   (w_at_limit),
    .o_grant      (w_grant),
    .o_owner      (w_grant_owner)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant)        w_state_next = StIssue;
      StIssue: if (mem_req_ready)  w_state_next = StWait;
      StWait:  if (mem_resp_valid) w_state_next = StIdle;
      default:                     w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_owner <= OwnI;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_fire) begin
        r_owner <= w_grant_owner;
        r_we    <= (w_grant_owner == OwnD) ? d_we : 1'b0;
        r_addr  <= (w_grant_owner == OwnD) ? d_addr : i_addr;
        r_wdata <= (w_grant_owner == OwnD) ? d_wdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop   <= 1'b0;
      r_streak <= '0;
    end else begin
      if (w_grant_fire) begin
        r_drop <= 1'b0;
      end else if (w_fetch_owned && i_flush) begin
        r_drop <= 1'b1;
      end
      if (!i_req) begin
        r_streak <= '0;
      end else if (w_grant_fire) begin
        if (w_grant_owner == OwnI) begin
          r_streak <= '0;
        end else if (!w_at_limit) begin
          r_streak <= r_streak + StreakW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_done <= w_i_deliver;
      r_d_done <= w_d_deliver;
      if (w_i_deliver) r_i_rdata <= mem_rdata;
      if (w_d_deliver) r_d_rdata <= mem_rdata;
    end
  end

  assign mem_req_valid = (r_state == StIssue);
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign i_done        = r_i_done;
  assign d_done        = r_d_done;
  assign i_rdata       = r_i_rdata;
  assign d_rdata       = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench: the bench plays core and memory, and predicts grant order and
// completion timing from a transaction-level timeline model.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_errors;

  // Reference model state
  int          m_streak;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  logic        m_exp_i_done;
  logic        m_exp_d_done;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (MaxStreak)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_flush        (i_flush),
    .i_done         (i_done),
    .i_rdata        (i_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_done         (d_done),
    .d_rdata        (d_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_completion();
    check("i_done", {31'd0, i_done}, {31'd0, m_exp_i_done});
    check("d_done", {31'd0, d_done}, {31'd0, m_exp_d_done});
    check("i_rdata", i_rdata, m_i_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    m_exp_i_done = 1'b0;
    m_exp_d_done = 1'b0;
  endtask

  // 0 = no grant, 1 = fetch, 2 = data
  function automatic int model_pick(input logic ireq, input logic ifl, input logic dreq);
    logic live;
    live = ireq && !ifl;
    if (dreq && !(live && m_streak == MaxStreak)) return 2;
    if (live) return 1;
    return 0;
  endfunction

  // One arbitration slot: an idle cycle, then (if granted) the whole transaction.
  // flush_at indexes the cycles after the grant: 0..rd are issue, rd+1..rd+lat are wait.
  task automatic run_slot(input logic ireq, input logic ifl, input logic dreq, input logic dwe,
                          input logic [31:0] iaddr, input logic [31:0] daddr,
                          input logic [31:0] dwdata, input int rd, input int lat,
                          input int flush_at, input logic spur, input logic [31:0] rdat);
    int          who;
    logic        drop;
    logic [31:0] exp_addr;
    i_req          = ireq;
    i_flush        = ifl;
    i_addr         = iaddr;
    d_req          = dreq;
    d_we           = dwe;
    d_addr         = daddr;
    d_wdata        = dwdata;
    mem_req_ready  = 1'b0;
    mem_resp_valid = spur;
    mem_rdata      = $urandom;
    @(negedge clk);
    check("idle_valid", {31'd0, mem_req_valid}, 32'd0);
    check_completion();
    who = model_pick(ireq, ifl, dreq);
    if (!ireq) m_streak = 0;
    else if (who == 1) m_streak = 0;
    else if (who == 2 && m_streak < MaxStreak) m_streak++;
    @(posedge clk); #1;
    if (who == 0) return;
    drop     = 1'b0;
    exp_addr = (who == 1) ? iaddr : daddr;
    for (int j = 0; j <= rd; j++) begin
      mem_req_ready  = (j == rd);
      mem_resp_valid = spur;
      mem_rdata      = $urandom;
      i_flush        = (flush_at == j);
      if (who == 1 && flush_at == j) drop = 1'b1;
      @(negedge clk);
      check("issue_valid", {31'd0, mem_req_valid}, 32'd1);
      check("issue_addr", mem_addr, exp_addr);
      check("issue_we", {31'd0, mem_we}, (who == 2) ? {31'd0, dwe} : 32'd0);
      if (who == 2) check("issue_wdata", mem_wdata, dwdata);
      check("issue_dones", {30'd0, i_done, d_done}, 32'd0);
      @(posedge clk); #1;
    end
    for (int j = 1; j <= lat; j++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = (j == lat);
      mem_rdata      = (j == lat) ? rdat : $urandom;
      i_flush        = (flush_at == rd + j);
      if (who == 1 && flush_at == rd + j) drop = 1'b1;
      @(negedge clk);
      check("wait_valid", {31'd0, mem_req_valid}, 32'd0);
      check("wait_dones", {30'd0, i_done, d_done}, 32'd0);
      @(posedge clk); #1;
    end
    i_flush = 1'b0;
    if (who == 1 && !drop) begin
      m_exp_i_done = 1'b1;
      m_i_rdata    = rdat;
    end
    if (who == 2) begin
      m_exp_d_done = 1'b1;
      m_d_rdata    = rdat;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {28'd0, i_done, d_done, mem_req_valid, mem_we}, 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic model_reset();
    m_streak     = 0;
    m_i_rdata    = '0;
    m_d_rdata    = '0;
    m_exp_i_done = 1'b0;
    m_exp_d_done = 1'b0;
  endtask

  initial begin
    int rd;
    int lat;
    int fa;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    reset = 1'b0;
    {i_req, i_flush, d_req, d_we, mem_req_ready, mem_resp_valid} = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Fetch only: done lands three cycles after the request
    run_slot(1, 0, 0, 0, 32'h40, 0, 0, 0, 1, -1, 0, 32'h0050_0093);
    // Both request together: data first, fetch issued right after d_done
    run_slot(0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    run_slot(1, 0, 1, 1, 32'h44, 32'h100, 32'hDEAD_BEEF, 0, 1, -1, 0, 32'h1111_2222);
    run_slot(1, 0, 0, 0, 32'h44, 0, 0, 0, 2, -1, 0, 32'h3333_4444);
    // Streak: D,D,D,D,I,D,D with both held
    run_slot(0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    for (int k = 0; k < 7; k++)
      run_slot(1, 0, 1, k[0], 32'h200, 32'h300 + k, $urandom, k % 3, 1 + k % 2, -1, 0, $urandom);
    // Memory stalls acceptance for 5 cycles
    run_slot(0, 0, 1, 1, 0, 32'h400, 32'hCAFE_F00D, 5, 2, -1, 0, $urandom);
    // Flush one cycle before the response drops the fetch; data follows normally
    run_slot(1, 0, 0, 0, 32'h80, 0, 0, 0, 3, 2, 0, 32'hBAD0_0001);
    run_slot(0, 0, 1, 0, 0, 32'h500, 0, 1, 1, -1, 0, 32'h5555_6666);
    // Flush in the response cycle also drops
    run_slot(1, 0, 0, 0, 32'h84, 0, 0, 1, 2, 3, 0, 32'hBAD0_0002);
    // Flush at idle suppresses the fetch grant
    run_slot(1, 1, 0, 0, 32'h88, 0, 0, 0, 1, -1, 0, 0);
    run_slot(1, 1, 1, 0, 32'h88, 32'h600, 0, 0, 1, -1, 1, $urandom);

    for (int n = 0; n < 200; n++) begin
      rd  = $urandom_range(0, 3);
      lat = $urandom_range(1, 3);
      fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rd + lat) : -1;
      run_slot($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, rd, lat, fa,
               $urandom_range(0, 4) == 0, $urandom);
    end
    run_slot(0, 0, 1, 0, 0, 32'h700, 0, 0, 1, -1, 0, 32'h7777_8888);

    // Reset while a fetch sits in WAIT
    i_req = 1'b1; i_addr = 32'h90; d_req = 1'b0; i_flush = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("pre_reset_d_rdata", d_rdata, m_d_rdata);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset");
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_valid", {31'd0, mem_req_valid}, 32'd0);
      check("post_reset_dones", {30'd0, i_done, d_done}, 32'd0);
    end
    @(posedge clk); #1;
    run_slot(1, 0, 1, 0, 32'hA0, 32'hB0, 0, 0, 1, -1, 0, 32'h9999_0000);
    run_slot(0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
